uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rx_sampler.sv | 51 +++++
 rtl/uart_rx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding,
// parity-mode character codes, the clocks-per-bit helper and the parity function.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam logic [7:0] PAR_NONE = 8'h4E;  // "N"
  localparam logic [7:0] PAR_EVEN = 8'h45;  // "E"
  localparam logic [7:0] PAR_ODD  = 8'h4F;  // "O"
  localparam logic [7:0] PAR_LOW  = 8'h4C;  // "L"
  localparam logic [7:0] PAR_HIGH = 8'h48;  // "H"

  function automatic int unsigned calc_cpb(input int unsigned clk_rate,
                                           input int unsigned baud_rate);
    return clk_rate / baud_rate;
  endfunction

  // Parity bit the transmitter should have sent for the low 'len' bits of 'word'.
  function automatic logic expected_parity(input logic [8:0]  word,
                                           input int unsigned len,
                                           input logic [7:0]  mode);
    logic x;
    x = 1'b0;
    for (int unsigned i = 0; i < 9; i++) begin
      x = x ^ (word[i] & (i < len));
    end
    case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      PAR_HIGH: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for uart_rx: 2-flop synchronizer, falling-edge detect and
// bit-value selection (2-of-3 majority when UART_RX_MAJORITY_EN is defined).
module uart_rx_sampler (
  input  logic clk_i,
  input  logic arst_n,
  input  logic rx_i,
  output logic line_s,
  output logic fall_s,
  output logic bit_s
);

  logic [1:0] sync_r;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_r;

  // Synchronizer and two-deep history of the synchronized line.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      sync_r <= 2'b11;
      hist_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_i};
      hist_r <= {hist_r[0], sync_r[1]};
    end
  end

  // The whole stream is viewed one clock late so the vote is centred on it.
  assign line_s = hist_r[0];
  assign fall_s = hist_r[1] & ~hist_r[0];
  assign bit_s  = (sync_r[1] & hist_r[0]) | (sync_r[1] & hist_r[1]) | (hist_r[0] & hist_r[1]);
`else
  logic hist_r;

  // Synchronizer and previous synchronized value for edge detection.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      sync_r <= 2'b11;
      hist_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], rx_i};
      hist_r <= sync_r[1];
    end
  end

  assign line_s = sync_r[1];
  assign fall_s = hist_r & ~sync_r[1];
  assign bit_s  = sync_r[1];
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver assembling WORD_COUNT frames into one block, with parity/stop
// checking and gap timeout. Optional macro: UART_RX_MAJORITY_EN (3-sample vote).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 10_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned WORD_LEN   = 8,
  parameter int unsigned WORD_COUNT = 8,
  parameter logic [7:0]  PARITY     = "L",
  parameter int unsigned STOP       = 1,
  parameter int unsigned GAP_BITS   = 16
) (
  input  logic                           clk_i,
  input  logic                           arst_n,
  input  logic                           rx_i,
  output logic [WORD_LEN*WORD_COUNT-1:0] rx_data_o,
  output logic                           rx_valid_o,
  output logic                           rx_busy_o,
  output logic                           rx_parity_err_o,
  output logic                           rx_frame_err_o
);

  localparam int unsigned CPB      = calc_cpb(CLK_RATE, BAUD_RATE);
  localparam int unsigned CNT_W    = $clog2(CPB + 1);
  localparam int unsigned GAP_CLKS = GAP_BITS * CPB;
  localparam int unsigned GAP_W    = $clog2(GAP_CLKS + 1);
  localparam int unsigned IDX_W    = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int unsigned BIT_W    = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam int unsigned BLK_W    = WORD_LEN * WORD_COUNT;

  logic line_s, fall_s, bit_s;

  rx_state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [BIT_W-1:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic                stop_cnt_r, stop_cnt_nxt_s;
  logic [WORD_LEN-1:0] data_r, data_nxt_s;
  logic [IDX_W-1:0]    word_idx_r, word_idx_nxt_s;
  logic [GAP_W-1:0]    gap_r, gap_nxt_s;
  logic [BLK_W-1:0]    shadow_r, shadow_nxt_s;
  logic [BLK_W-1:0]    rx_data_r, rx_data_nxt_s;
  logic                valid_r, valid_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                perr_r, perr_nxt_s;
  logic                ferr_r, ferr_nxt_s;
  logic                tick_s;

  uart_rx_sampler u_sampler (
    .clk_i  (clk_i),
    .arst_n (arst_n),
    .rx_i   (rx_i),
    .line_s (line_s),
    .fall_s (fall_s),
    .bit_s  (bit_s)
  );

  // Next-state, datapath and output-pulse logic.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    stop_cnt_nxt_s = stop_cnt_r;
    data_nxt_s     = data_r;
    word_idx_nxt_s = word_idx_r;
    gap_nxt_s      = '0;
    shadow_nxt_s   = shadow_r;
    rx_data_nxt_s  = rx_data_r;
    valid_nxt_s    = 1'b0;
    perr_nxt_s     = 1'b0;
    ferr_nxt_s     = 1'b0;
    tick_s         = (cnt_r == '0);

    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_nxt_s = ST_START;
          cnt_nxt_s   = CNT_W'(CPB / 2);
        end else if ((word_idx_r != '0) && line_s) begin
          // Idle line with a partial block pending: abandon it after the gap.
          if (gap_r == GAP_W'(GAP_CLKS - 1)) begin
            word_idx_nxt_s = '0;
            ferr_nxt_s     = 1'b1;
          end else begin
            gap_nxt_s = gap_r + GAP_W'(1);
          end
        end else begin
          gap_nxt_s = '0;
        end
      end
      ST_START: begin
        if (!tick_s) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else if (!bit_s) begin
          state_nxt_s   = ST_DATA;
          cnt_nxt_s     = CNT_W'(CPB - 1);
          bit_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!tick_s) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
          data_nxt_s = {bit_s, data_r[WORD_LEN-1:1]};
          cnt_nxt_s  = CNT_W'(CPB - 1);
          if (bit_cnt_r == BIT_W'(WORD_LEN - 1)) begin
            state_nxt_s    = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            stop_cnt_nxt_s = 1'b0;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (!tick_s) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
          perr_nxt_s     = (bit_s != expected_parity(9'(data_r), WORD_LEN, PARITY));
          state_nxt_s    = ST_STOP;
          cnt_nxt_s      = CNT_W'(CPB - 1);
          stop_cnt_nxt_s = 1'b0;
        end
      end
      ST_STOP: begin
        if (!tick_s) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else if (!bit_s) begin
          ferr_nxt_s     = 1'b1;
          word_idx_nxt_s = '0;
          state_nxt_s    = ST_WAIT_HIGH;
          cnt_nxt_s      = CNT_W'(CPB - 1);
        end else if (stop_cnt_r == 1'(STOP - 1)) begin
          shadow_nxt_s[int'(word_idx_r)*WORD_LEN +: WORD_LEN] = data_r;
          state_nxt_s = ST_IDLE;
          if (word_idx_r == IDX_W'(WORD_COUNT - 1)) begin
            rx_data_nxt_s  = shadow_nxt_s;
            valid_nxt_s    = 1'b1;
            word_idx_nxt_s = '0;
          end else begin
            word_idx_nxt_s = word_idx_r + IDX_W'(1);
          end
        end else begin
          stop_cnt_nxt_s = 1'b1;
          cnt_nxt_s      = CNT_W'(CPB - 1);
        end
      end
      ST_WAIT_HIGH: begin
        // Break handling: need one uninterrupted bit-time of high line.
        if (!line_s) begin
          cnt_nxt_s = CNT_W'(CPB - 1);
        end else if (tick_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s == ST_START) || (state_nxt_s == ST_DATA) ||
                 (state_nxt_s == ST_PARITY) || (state_nxt_s == ST_STOP);
  end

  // State register, datapath registers and registered outputs.
  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      bit_cnt_r  <= '0;
      stop_cnt_r <= 1'b0;
      data_r     <= '0;
      word_idx_r <= '0;
      gap_r      <= '0;
      shadow_r   <= '0;
      rx_data_r  <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      stop_cnt_r <= stop_cnt_nxt_s;
      data_r     <= data_nxt_s;
      word_idx_r <= word_idx_nxt_s;
      gap_r      <= gap_nxt_s;
      shadow_r   <= shadow_nxt_s;
      rx_data_r  <= rx_data_nxt_s;
      valid_r    <= valid_nxt_s;
      busy_r     <= busy_nxt_s;
      perr_r     <= perr_nxt_s;
      ferr_r     <= ferr_nxt_s;
    end
  end

  assign rx_data_o       = rx_data_r;
  assign rx_valid_o      = valid_r;
  assign rx_busy_o       = busy_r;
  assign rx_parity_err_o = perr_r;
  assign rx_frame_err_o  = ferr_r;

endmodule
